// File: rtl/wb_register_file.sv
// Writeback register file: 32 GPRs plus HI/LO with same-cycle bypass.
// Also keeps a running count of committed writes for the debug port.
module wb_register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_rf_en,
  input  logic        wb_hi_en,
  input  logic        wb_lo_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic [31:0] commit_count,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs [32];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] commit_q;

  logic        gpr_we;
  logic [1:0]  n_commits;

  // r0 is hardwired to zero, so a write aimed at it is not a write at all.
  assign gpr_we = wb_rf_en && (wb_dest != 5'd0);

  assign n_commits = {1'b0, gpr_we}
                   + {1'b0, wb_hi_en}
                   + {1'b0, wb_lo_en};

  // GPR storage; reset clears every entry without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (gpr_we) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // HI/LO storage, written independently of the GPR enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_hi_en) hi_q <= wb_data;
      if (wb_lo_en) lo_q <= wb_data;
    end
  end

  // Commit counter: 0..3 events per edge, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_q <= '0;
    end else begin
      commit_q <= commit_q + {30'd0, n_commits};
    end
  end

  assign commit_count = commit_q;

  // rs read: zero register, then bypass from writeback, then storage.
  always_comb begin
    rs_data = regs[rs_addr];
    unique case (1'b1)
      (rs_addr == 5'd0):             rs_data = '0;
      (gpr_we && rs_addr == wb_dest): rs_data = wb_data;
      default:                       rs_data = regs[rs_addr];
    endcase
  end

  // rt read: same priority as the rs port.
  always_comb begin
    rt_data = regs[rt_addr];
    unique case (1'b1)
      (rt_addr == 5'd0):             rt_data = '0;
      (gpr_we && rt_addr == wb_dest): rt_data = wb_data;
      default:                       rt_data = regs[rt_addr];
    endcase
  end

  // HI/LO reads forward the value being written this cycle.
  always_comb begin
    hi_data = wb_hi_en ? wb_data : hi_q;
    lo_data = wb_lo_en ? wb_data : lo_q;
  end

  // Debug port shows committed state only, never the bypass.
  always_comb begin
    dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file.
// Drives on the falling edge, samples #1 after edges.
module tb_wb_register_file;

  logic        clk;
  logic        reset;
  logic        wb_rf_en;
  logic        wb_hi_en;
  logic        wb_lo_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [31:0] commit_count;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_pass;
  int n_total;

  wb_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .wb_rf_en     (wb_rf_en),
    .wb_hi_en     (wb_hi_en),
    .wb_lo_en     (wb_lo_en),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .hi_data      (hi_data),
    .lo_data      (lo_data),
    .commit_count (commit_count),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    @(negedge clk);
    wb_rf_en = 1'b0;
    wb_hi_en = 1'b0;
    wb_lo_en = 1'b0;
    wb_dest  = 5'd0;
    wb_data  = 32'd0;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1;
      n_total++;
      if (dbg_data !== 32'd0)
        $display("FAIL reset_gpr%0d got %h exp 0", i, dbg_data);
      else n_pass++;
    end
    n_total++;
    if (hi_data !== 32'd0 || lo_data !== 32'd0)
      $display("FAIL reset_hilo got %h/%h exp 0", hi_data, lo_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd0)
      $display("FAIL reset_count got %h exp 0", commit_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    wb_rf_en = 1'b1;
    wb_dest  = 5'd5;
    wb_data  = 32'h1234_5678;
    rs_addr  = 5'd5;
    dbg_addr = 5'd5;
    #1;
    n_total++;
    if (rs_data !== 32'h1234_5678)
      $display("FAIL wr_bypass got %h exp 12345678", rs_data);
    else n_pass++;
    n_total++;
    if (dbg_data !== 32'd0)
      $display("FAIL wr_dbg_before got %h exp 0", dbg_data);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (dbg_data !== 32'h1234_5678)
      $display("FAIL wr_dbg_after got %h exp 12345678", dbg_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd1)
      $display("FAIL wr_count got %h exp 1", commit_count);
    else n_pass++;
    idle();
  endtask

  task automatic test_r0();
    @(negedge clk);
    wb_rf_en = 1'b1;
    wb_dest  = 5'd0;
    wb_data  = 32'hDEAD_BEEF;
    rs_addr  = 5'd0;
    rt_addr  = 5'd0;
    dbg_addr = 5'd0;
    #1;
    n_total++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0)
      $display("FAIL r0_before got %h/%h exp 0", rs_data, rt_data);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (rs_data !== 32'd0 || dbg_data !== 32'd0)
      $display("FAIL r0_after got %h/%h exp 0", rs_data, dbg_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd1)
      $display("FAIL r0_count got %h exp 1", commit_count);
    else n_pass++;
    n_total++;
    if (hi_data !== 32'd0 || lo_data !== 32'd0)
      $display("FAIL r0_hilo got %h/%h exp 0", hi_data, lo_data);
    else n_pass++;
    idle();
  endtask

  task automatic test_triple();
    @(negedge clk);
    wb_rf_en = 1'b1;
    wb_hi_en = 1'b1;
    wb_lo_en = 1'b1;
    wb_dest  = 5'd31;
    wb_data  = 32'hA5A5_A5A5;
    rt_addr  = 5'd31;
    dbg_addr = 5'd31;
    #1;
    n_total++;
    if (hi_data !== 32'hA5A5_A5A5 || lo_data !== 32'hA5A5_A5A5
        || rt_data !== 32'hA5A5_A5A5)
      $display("FAIL tri_bypass got %h/%h/%h exp a5a5a5a5",
               hi_data, lo_data, rt_data);
    else n_pass++;
    n_total++;
    if (dbg_data !== 32'd0)
      $display("FAIL tri_dbg_before got %h exp 0", dbg_data);
    else n_pass++;
    @(posedge clk);
    idle();
    #1;
    n_total++;
    if (dbg_data !== 32'hA5A5_A5A5)
      $display("FAIL tri_r31 got %h exp a5a5a5a5", dbg_data);
    else n_pass++;
    n_total++;
    if (hi_data !== 32'hA5A5_A5A5 || lo_data !== 32'hA5A5_A5A5)
      $display("FAIL tri_hilo got %h/%h exp a5a5a5a5", hi_data, lo_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd4)
      $display("FAIL tri_count got %h exp 4", commit_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wb_rf_en = 1'b1;
    wb_dest  = 5'd7;
    wb_data  = 32'd1;
    rs_addr  = 5'd7;
    rt_addr  = 5'd7;
    dbg_addr = 5'd7;
    @(negedge clk);
    wb_data  = 32'd2;
    #1;
    n_total++;
    if (rs_data !== 32'd2 || rt_data !== 32'd2)
      $display("FAIL b2b_bypass got %h/%h exp 2", rs_data, rt_data);
    else n_pass++;
    n_total++;
    if (dbg_data !== 32'd1)
      $display("FAIL b2b_dbg_old got %h exp 1", dbg_data);
    else n_pass++;
    @(posedge clk);
    idle();
    #1;
    n_total++;
    if (dbg_data !== 32'd2 || rs_data !== 32'd2)
      $display("FAIL b2b_stored got %h/%h exp 2", dbg_data, rs_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd6)
      $display("FAIL b2b_count got %h exp 6", commit_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    dut.commit_q = 32'hFFFF_FFFE;
    wb_hi_en = 1'b1;
    wb_lo_en = 1'b1;
    wb_data  = 32'h11;
    @(posedge clk);
    #1;
    n_total++;
    if (commit_count !== 32'd0)
      $display("FAIL wrap_zero got %h exp 0", commit_count);
    else n_pass++;
    @(negedge clk);
    dut.commit_q = 32'hFFFF_FFFF;
    wb_data  = 32'h22;
    @(posedge clk);
    #1;
    n_total++;
    if (commit_count !== 32'd1)
      $display("FAIL wrap_one got %h exp 1", commit_count);
    else n_pass++;
    n_total++;
    if (hi_data !== 32'h22 || lo_data !== 32'h22)
      $display("FAIL wrap_hilo got %h/%h exp 22", hi_data, lo_data);
    else n_pass++;
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wb_rf_en = 1'b1;
    wb_dest  = 5'd3;
    wb_data  = 32'h55;
    @(negedge clk);
    wb_data  = 32'h99;
    rs_addr  = 5'd3;
    dbg_addr = 5'd3;
    #1;
    n_total++;
    if (dbg_data !== 32'h55)
      $display("FAIL ar_stored got %h exp 55", dbg_data);
    else n_pass++;
    #1;
    reset = 1'b1;
    #1;
    n_total++;
    if (dbg_data !== 32'd0)
      $display("FAIL ar_immediate got %h exp 0", dbg_data);
    else n_pass++;
    n_total++;
    if (commit_count !== 32'd0 || hi_data !== 32'd0)
      $display("FAIL ar_count got %h/%h exp 0", commit_count, hi_data);
    else n_pass++;
    n_total++;
    if (rs_data !== 32'h99)
      $display("FAIL ar_bypass got %h exp 99", rs_data);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (dbg_data !== 32'd0 || commit_count !== 32'd0)
        $display("FAIL ar_held%0d got %h/%h exp 0",
                 k, dbg_data, commit_count);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (dbg_data !== 32'h99 || commit_count !== 32'd1)
      $display("FAIL ar_first_write got %h/%h exp 99/1",
               dbg_data, commit_count);
    else n_pass++;
    idle();
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    wb_rf_en = 1'b0;
    wb_hi_en = 1'b0;
    wb_lo_en = 1'b0;
    wb_dest  = 5'd0;
    wb_data  = 32'd0;
    rs_addr  = 5'd0;
    rt_addr  = 5'd0;
    dbg_addr = 5'd0;
    test_reset();
    test_basic_write();
    test_r0();
    test_triple();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
REQ-001 SHALL have ports: clk input 1 (clock, all state updates on rising edge); reset input 1 (asynchronous, active-high).
REQ-002 SHALL have wb_rf_en input 1: commit wb_data to general register wb_dest this edge.
REQ-003 SHALL have wb_hi_en input 1 and wb_lo_en input 1: commit wb_data to HI, LO respectively.
REQ-004 SHALL have wb_dest input 5: resolved writeback destination (rd or 31 for link, already chosen upstream).
REQ-005 SHALL have wb_data input 32: writeback value from the MEM/WB pipeline register.
REQ-006 SHALL have rs_addr input 5, rt_addr input 5: decode-stage read addresses.
REQ-007 SHALL have rs_data output 32, rt_data output 32: combinational read data.
REQ-008 SHALL have hi_data output 32, lo_data output 32: combinational HI/LO read data.
REQ-009 SHALL have commit_count output 32: registered count of committed writes.
REQ-010 SHALL have dbg_addr input 5, dbg_data output 32: third read port, no bypass, for bench/debug.

Function
REQ-011 SHALL hold 32 general registers x 32 bits, plus HI and LO, 32 bits each.
REQ-012 SHALL write regs[wb_dest] <= wb_data on a rising edge when wb_rf_en=1 and wb_dest!=0.
REQ-013 SHALL ignore writes to register 0; rs_data/rt_data/dbg_data for address 0 SHALL always read 0.
REQ-014 SHALL write HI <= wb_data when wb_hi_en=1 and LO <= wb_data when wb_lo_en=1, independently of wb_rf_en; all three enables may assert in the same cycle and all three writes SHALL occur.
REQ-015 SHALL bypass: if wb_rf_en=1, wb_dest!=0 and rs_addr==wb_dest, rs_data SHALL equal wb_data in the same cycle (before the edge); rt_data likewise.
REQ-016 SHALL bypass HI/LO: hi_data equals wb_data while wb_hi_en=1; lo_data equals wb_data while wb_lo_en=1.
REQ-017 SHALL NOT bypass dbg_data; it reflects stored state only, updated one edge after the write.
REQ-018 SHALL otherwise read stored values combinationally, with zero added latency.
REQ-019 SHALL increment commit_count by the number of asserted effective write events per edge (effective GPR write, HI write, LO write: 0..3).
REQ-020 SHALL wrap commit_count modulo 2^32 (0xFFFFFFFF + 1 -> 0x00000000, +2 -> 0x00000001).
REQ-021 SHALL NOT count a GPR write with wb_dest=0.
REQ-022 SHALL make wb_rf_en with wb_dest=0 and wb_hi_en=wb_lo_en=0 a complete no-op.

Reset
REQ-023 SHALL on reset=1 immediately clear all 32 GPRs, HI, LO and commit_count to 0, with no clock required.
REQ-024 SHALL suppress all writes and counting while reset=1, regardless of enables.
REQ-025 SHALL keep bypass paths combinational during reset, so rs_data shows wb_data on an address match while reset=1; stored state stays 0.
REQ-026 SHALL accept the first write on the first rising edge after reset deasserts.

Verification
REQ-027 Reset then write r5=0x12345678 (wb_rf_en=1) -> rs_addr=5 reads 0x12345678 before the edge; dbg_addr=5 reads 0 before and 0x12345678 after; commit_count=1.
REQ-028 wb_rf_en=1, wb_dest=0, wb_data=0xDEADBEEF -> rs_addr=0 reads 0 in all cycles; commit_count unchanged.
REQ-029 wb_rf_en=wb_hi_en=wb_lo_en=1, wb_dest=31, wb_data=0xA5A5A5A5 -> r31, HI and LO all equal 0xA5A5A5A5 after the edge; commit_count +3.
REQ-030 Write r7=0x1, then next cycle write r7=0x2 with rs_addr=rt_addr=7 -> both ports read 0x2 in the second cycle (bypass beats stored 0x1).
REQ-031 Force commit_count to 0xFFFFFFFE via writes or hierarchical preset, then commit a HI+LO write -> commit_count=0x00000000.
REQ-032 Assert reset mid-cycle, asynchronously, with r3=0x55 stored and wb_rf_en=1 -> dbg r3 reads 0 immediately; r3 stays 0 through every edge while reset is held; the write is lost.
